shared_tick_timer: RTL and testbench

SHARED_TICK_TIMER -- requirements
Module: shared_tick_timer

---
 rtl/shared_tick_timer_pkg.sv | 15 +
 rtl/shared_tick_timer_prescaler.sv | 29 ++
 rtl/shared_tick_timer.sv | 139 +++++++++++++
 tb/tb_shared_tick_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_tick_timer_pkg.sv
// Shared definitions for the shared tick timer: FSM state encoding and
// default sizing constants.
package shared_tick_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tt_state_e;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_PRESCALE_M = 10;

endpackage

// File: rtl/shared_tick_timer_prescaler.sv
// Tick prescaler: counts 0..PRESCALE_M-1 while enabled and flags the
// terminal count as a one-cycle tick.
module tick_prescaler #(
    parameter int PRESCALE_M = 10,
    parameter int CW         = $clog2(PRESCALE_M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] TERM = CW'(PRESCALE_M - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == TERM) ? '0 : count + CW'(1);
        end
    end

    assign tick = enable && (count == TERM);

endmodule

// File: rtl/shared_tick_timer.sv
// Round-robin shared tick timer: grants one requester at a time and pulses
// done after cnt prescaled ticks. Optional feature: SHARED_TICK_TIMER_CANCEL_EN
// lets the granted requester abort its service by dropping req.
module shared_tick_timer
    import shared_tick_timer_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PRESCALE_M = DEF_PRESCALE_M
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] cnt,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   tick
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int PS_W  = $clog2(PRESCALE_M);

    tt_state_e        state, state_next;
    logic [1:0]       rst_q;
    logic             rst_n;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_found;
    logic [CNT_W-1:0] pick_cnt;
    logic [CNT_W-1:0] remaining;
    logic [PS_W-1:0]  ps_count;
    logic             load, dec, done_set, leave;
    int               j;

    // Assertion is immediate; release is seen by the core two edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!pick_found && req[PTR_W'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(j);
            end
        end
    end

    assign pick_cnt = cnt[pick_idx*CNT_W +: CNT_W];

    tick_prescaler #(.PRESCALE_M(PRESCALE_M), .CW(PS_W)) u_prescaler (
        .clk    (clk),
        .reset  (rst_n),
        .clear  (state != ST_RUN),
        .enable (state == ST_RUN),
        .tick   (tick),
        .count  (ps_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        dec        = 1'b0;
        done_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    load       = 1'b1;
                    state_next = (pick_cnt != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    if (remaining == CNT_W'(1)) begin
                        state_next = ST_DONE;
                        done_set   = 1'b1;
                    end else begin
                        dec = 1'b1;
                    end
                end
`ifdef SHARED_TICK_TIMER_CANCEL_EN
                if (!(|(req & gnt))) begin
                    state_next = ST_IDLE;
                    done_set   = 1'b0;
                    dec        = 1'b0;
                end
`endif
            end
            ST_DONE: begin
                // Zero-count services arrive here without done raised yet.
                if (|done) state_next = ST_IDLE;
                else       done_set   = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign leave = (state != ST_IDLE) && (state_next == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            done      <= '0;
            remaining <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load) begin
                gnt       <= N_REQ'(1) << pick_idx;
                remaining <= pick_cnt;
                rr_ptr    <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            end
            if (dec) remaining <= remaining - CNT_W'(1);
            if (done_set) begin
                done      <= gnt;
                remaining <= '0;
            end
            if (leave) begin
                gnt  <= '0;
                done <= '0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_shared_tick_timer.sv
// Scoreboard bench for shared_tick_timer: expected grants and completions are
// queued as stimulus is applied and checked by a negedge monitor.
module tb_shared_tick_timer;

    localparam int N = 4;
    localparam int W = 8;
    localparam int M = 10;

    typedef struct {
        logic [N-1:0] val;
        int           cyc;
        bit           min;
    } g_t;

    typedef struct {
        logic [N-1:0] val;
        int           dly;
        int           ticks;
    } d_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] cnt;
    logic [N-1:0]   gnt, done;
    logic           busy, tick;

    g_t exp_gnt[$];
    d_t exp_done[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int gnt_cyc = 0;
    int tick_cnt = 0;
    logic [N-1:0] gnt_prev = '0;
    logic [N-1:0] done_prev = '0;

    shared_tick_timer #(.N_REQ(N), .CNT_W(W), .PRESCALE_M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .cnt   (cnt),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .tick  (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        g_t g;
        d_t d;
        if (tick) begin
            tick_cnt++;
            chk("tick_phase", (cyc - gnt_cyc) % M, M - 1);
        end
        if (gnt != '0 && gnt_prev == '0) begin
            if (exp_gnt.size() == 0) begin
                chk("gnt_unexp", gnt, 0);
            end else begin
                g = exp_gnt.pop_front();
                chk("gnt_val", gnt, g.val);
                if (g.min) chk("gnt_min", cyc >= g.cyc, 1);
                else       chk("gnt_cyc", cyc, g.cyc);
            end
            gnt_cyc  = cyc;
            tick_cnt = 0;
        end
        if (done != '0) begin
            chk("done_width", done_prev, 0);
            chk("done_on_gnt", done, gnt);
            if (exp_done.size() == 0) begin
                chk("done_unexp", done, 0);
            end else if (done_prev == '0) begin
                d = exp_done.pop_front();
                chk("done_val", done, d.val);
                chk("done_dly", cyc - gnt_cyc, d.dly);
                chk("done_ticks", tick_cnt, d.ticks);
            end
        end
        gnt_prev  = gnt;
        done_prev = done;
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cnt(input int i, input int v);
        cnt[i*W +: W] = W'(v);
    endtask

    task automatic push_g(input int i, input int c, input bit mn);
        g_t g;
        g.val = N'(1) << i;
        g.cyc = c;
        g.min = mn;
        exp_gnt.push_back(g);
    endtask

    task automatic push_d(input int i, input int dly, input int t);
        d_t d;
        d.val   = N'(1) << i;
        d.dly   = dly;
        d.ticks = t;
        exp_done.push_back(d);
    endtask

    task automatic serve(input int i, input int c);
        int k, dly;
        set_cnt(i, c);
        req[i] = 1'b1;
        k   = cyc;
        dly = (c == 0) ? 1 : c * M;
        push_g(i, k + 1, 1'b0);
        push_d(i, dly, c);
        nclk(1 + dly);
        req[i] = 1'b0;
        nclk(1);
        chk("busy_after", busy, 0);
        nclk(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k, r, n;
        reset = 1'b0;
        req   = '0;
        cnt   = '0;
        nclk(2);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        reset = 1'b1;
        nclk(4);

        // All requesters held with cnt=1: 0,1,2,3,0 at 12-cycle spacing.
        for (int i = 0; i < N; i++) set_cnt(i, 1);
        req = '1;
        k = cyc;
        for (int s = 0; s < 5; s++) begin
            push_g(s % N, k + 1 + 12 * s, 1'b0);
            push_d(s % N, M, 1);
        end
        nclk(59);
        req = '0;
        nclk(1);
        chk("busy_rr", busy, 0);
        nclk(2);

        serve(0, 3);
        serve(2, 0);
        serve(3, 255);

        // Granted requester's cnt changes mid-service are ignored.
        set_cnt(0, 5);
        set_cnt(1, 2);
        req = 4'b0001;
        k = cyc;
        push_g(0, k + 1, 1'b0);
        push_d(0, 50, 5);
        push_g(1, k + 53, 1'b0);
        push_d(1, 20, 2);
        nclk(13);
        set_cnt(0, 1);
        req[1] = 1'b1;
        nclk(38);
        req[0] = 1'b0;
        nclk(22);
        req[1] = 1'b0;
        nclk(2);
        chk("busy_ign", busy, 0);

        // Reset mid-service aborts; held req gets a fresh full service.
        set_cnt(0, 4);
        req = 4'b0001;
        k = cyc;
        push_g(0, k + 1, 1'b0);
        nclk(26);
        reset = 1'b0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tick", tick, 0);
        nclk(3);
        r = cyc;
        reset = 1'b1;
        push_g(0, r + 2, 1'b1);
        push_d(0, 4 * M, 4);
        n = 0;
        while (done[0] !== 1'b1 && n < 100) begin
            nclk(1);
            n++;
        end
        chk("wait_done_rst", n < 100, 1);
        req = '0;
        nclk(2);

        // Granted requester drops req during RUN.
        set_cnt(0, 4);
        req = 4'b0001;
        k = cyc;
        push_g(0, k + 1, 1'b0);
`ifdef SHARED_TICK_TIMER_CANCEL_EN
        nclk(16);
        req = '0;
        nclk(1);
        chk("cancel_gnt", gnt, 0);
        chk("cancel_busy", busy, 0);
        nclk(45);
`else
        push_d(0, 4 * M, 4);
        nclk(16);
        req = '0;
        nclk(25);
        nclk(2);
        chk("nocancel_busy", busy, 0);
`endif

        nclk(3);
        chk("gq_empty", exp_gnt.size(), 0);
        chk("dq_empty", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
